dmem_responder: RTL and testbench

- Data-memory responder on the far end of the pipeline MEM-stage load/store interface.
- Accepts one load or store request at a time from the MEM stage.
- Services it against an internal word-addressed RAM after a configurable latency.
- Returns a one-cycle acknowledge with read data or an error flag; the pipeline holds MEM and earlier stages while a request is outstanding.

---
 rtl/mem_if_pkg.sv | 23 ++
 rtl/dmem_ram_be.sv | 30 +++
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the MEM-stage data-memory interface.
package mem_if_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 8 * WORD_BYTES;
  localparam int unsigned BADDR_W    = 32;

  localparam logic [WORD_BYTES-1:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                  we;
    logic [BADDR_W-1:0]    addr;
    logic [DATA_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port word RAM: synchronous byte-enabled write, asynchronous read.
module dmem_ram_be
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; lanes with be low keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one MEM-stage load/store, answers after LATENCY cycles.
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [BADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [WORD_BYTES-1:0] be,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  stall
);

  localparam int unsigned CNT_W = 4;

  dmem_state_t        state;
  mem_req_t           hold;
  logic [CNT_W-1:0]   cnt;

  logic [ADDR_W-1:0]  word_addr_c;
  logic               misaligned_c;
  logic               out_of_range_c;
  logic               req_err_c;
  logic               ram_we_c;
  logic [DATA_W-1:0]  ram_rdata_c;

  // Error classification on the captured request.
  assign word_addr_c    = hold.addr[ADDR_W+1:2];
  assign misaligned_c   = (hold.addr[1:0] != 2'b00) && (!hold.we || (hold.be == BE_FULL));
  assign out_of_range_c = (hold.addr >> (ADDR_W + 2)) != BADDR_W'(0);
  assign req_err_c      = misaligned_c | out_of_range_c;

  // Store commits on the edge that leaves RESP, so a following load sees it.
  assign ram_we_c = (state == RESP) && hold.we && !err;

  assign stall = req & ~ack;

  dmem_ram_be #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .addr    (word_addr_c),
    .be      (hold.be),
    .wdata   (hold.wdata),
    .rdata_c (ram_rdata_c)
  );

  // Request FSM; every request spends LATENCY cycles in WAIT so ack lands exactly LATENCY edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      ack   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            hold  <= '{we: we, addr: addr, wdata: wdata, be: be};
            cnt   <= CNT_W'(LATENCY - 1);
            ready <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= req_err_c;
            rdata <= (req_err_c || hold.we) ? '0 : ram_rdata_c;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, errors, latency sweep, reset abort.
module tb_dmem_responder;
  import mem_if_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, ack, err, stall;
  logic [31:0] rdata;

  logic [1:0]  req_l;
  logic [1:0]  ready_l, ack_l, err_l, stall_l;
  logic [31:0] rdata_l [2];
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .ack(ack), .rdata(rdata), .err(err), .stall(stall)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req_l[0]), .we(lat_we), .addr(lat_addr), .wdata(lat_wdata), .be(lat_be),
    .ready(ready_l[0]), .ack(ack_l[0]), .rdata(rdata_l[0]), .err(err_l[0]), .stall(stall_l[0])
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .req(req_l[1]), .we(lat_we), .addr(lat_addr), .wdata(lat_wdata), .be(lat_be),
    .ready(ready_l[1]), .ack(ack_l[1]), .rdata(rdata_l[1]), .err(err_l[1]), .stall(stall_l[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack of the main DUT retires the oldest expected response.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, " err"}, 32'(err), 32'(e.err));
        if (!e.we) check({e.name, " rdata"}, rdata, e.rdata);
        check({e.name, " latency"}, 32'(cyc - e.acc), LAT);
      end
    end
  end

  // Issue one request on the main DUT and hold it until ack.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_err, input string name,
                       input bit scramble = 1'b0, input logic [31:0] sa = '0, input logic [31:0] sd = '0);
    int n;
    bit busy_ok;
    @(negedge clk);
    for (n = 0; n < 40 && !ready; n++) @(negedge clk);
    check({name, " ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    exp_q.push_back('{we: w, rdata: exp_rd, err: exp_err, acc: cyc + 1, name: name});
    busy_ok = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack) break;
      if (ready || !stall) busy_ok = 1'b0;
      if (scramble && n == 0) begin
        addr  = sa;
        wdata = sd;
      end
    end
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    check({name, " ack_seen"}, 32'(ack), 32'd1);
    check({name, " stall_at_ack"}, 32'(stall), 32'd0);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
  endtask

  // Latency sweep on the LATENCY=1 / LATENCY=15 instances.
  task automatic lat_test(input int idx, input int lat, input string name);
    int n;
    bit busy_ok;
    @(negedge clk);
    check({name, " ready_before"}, 32'(ready_l[idx]), 32'd1);
    req_l[idx] = 1'b1;
    busy_ok = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (ack_l[idx]) break;
      if (ready_l[idx]) busy_ok = 1'b0;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    check({name, " err"}, 32'(err_l[idx]), 32'd0);
    req_l[idx] = 1'b0;
    @(negedge clk);
    check({name, " single_pulse"}, 32'(ack_l[idx]), 32'd0);
    check({name, " ready_after"}, 32'(ready_l[idx]), 32'd1);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req_l = '0; lat_we = 1'b1; lat_addr = 32'h4; lat_wdata = 32'hFFFF_FFFF; lat_be = 4'h0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset ack",   32'(ack),   32'd0);
    check("reset err",   32'(err),   32'd0);
    check("reset rdata", rdata,      32'd0);
    check("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Known background contents.
    issue(1'b1, 32'h0,  32'h1234_5678, 4'hF, '0, 1'b0, "init_0x0");
    issue(1'b1, 32'h44, 32'h0,         4'hF, '0, 1'b0, "init_0x44");
    issue(1'b1, 32'h20, 32'h0,         4'hF, '0, 1'b0, "init_0x20");

    // Store then load.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, '0,           1'b0, "st_0x10");
    issue(1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "ld_0x10");

    // Byte-enable store.
    issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101, '0,           1'b0, "st_be0101");
    issue(1'b0, 32'h10, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0, "ld_be0101");

    // Error cases.
    issue(1'b0, 32'h13,   32'h0,         4'h0, 32'h0,         1'b1, "ld_misaligned");
    issue(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, '0,            1'b1, "st_out_of_range");
    issue(1'b0, 32'h0,    32'h0,         4'h0, 32'h1234_5678, 1'b0, "ld_0x0_unchanged");
    issue(1'b0, 32'h1000, 32'h0,         4'h0, 32'h0,         1'b1, "ld_out_of_range");
    issue(1'b1, 32'h11,   32'hFFFF_FFFF, 4'hF, '0,            1'b1, "st_misaligned_full");

    // Misaligned partial store is legal; be=0 store changes nothing.
    issue(1'b1, 32'h12, 32'h0000_AA55, 4'b0011, '0,           1'b0, "st_misaligned_partial");
    issue(1'b0, 32'h10, 32'h0,         4'h0,    32'hDE22_AA55, 1'b0, "ld_after_partial");
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0,    '0,           1'b0, "st_be0");
    issue(1'b0, 32'h10, 32'h0,         4'h0,    32'hDE22_AA55, 1'b0, "ld_after_be0");

    // Inputs changed during WAIT must not affect the captured request.
    issue(1'b1, 32'h40, 32'h5566_7788, 4'hF, '0, 1'b0, "st_scrambled", 1'b1, 32'h44, 32'hFFFF_FFFF);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h5566_7788, 1'b0, "ld_0x40_captured");
    issue(1'b0, 32'h44, 32'h0, 4'h0, 32'h0,         1'b0, "ld_0x44_untouched");
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h5566_7788, 1'b0, "ld_0x40_again");

    // Reset while a store to 0x20 is pending.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; be = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst ack",   32'(ack),   32'd0);
    check("midrst err",   32'(err),   32'd0);
    check("midrst rdata", rdata,      32'd0);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, "ld_0x20_after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    lat_test(0, 1,  "lat1");
    lat_test(1, 15, "lat15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
